// File: rtl/ebr_write_sequencer_if.sv
// Bus bundle between the I2C memory writer, the read requester, the two EBR banks
// and the ebr_write_sequencer.
interface ebr_write_sequencer_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  wr_active;
  logic                  wr_select;
  logic                  wr_strobe;
  logic [7:0]            wr_data;
  logic                  rd_req;
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [7:0]            rd_data;
  logic [ADDR_WIDTH-1:0] ebr_addr;
  logic [7:0]            ebr_wdata;
  logic [1:0]            ebr_we;
  logic [1:0]            ebr_re;
  logic [7:0]            ebr_rdata0;
  logic [7:0]            ebr_rdata1;
  logic [ADDR_WIDTH:0]   frame_len0;
  logic [ADDR_WIDTH:0]   frame_len1;
  logic                  frame_done;
  logic                  frame_bank;
  logic                  overflow;

  modport master (
    output wr_active, wr_select, wr_strobe, wr_data,
    output rd_req, rd_bank, rd_addr, ebr_rdata0, ebr_rdata1,
    input  rd_gnt, rd_valid, rd_data, ebr_addr, ebr_wdata, ebr_we, ebr_re,
    input  frame_len0, frame_len1, frame_done, frame_bank, overflow
  );

  modport slave (
    input  wr_active, wr_select, wr_strobe, wr_data,
    input  rd_req, rd_bank, rd_addr, ebr_rdata0, ebr_rdata1,
    output rd_gnt, rd_valid, rd_data, ebr_addr, ebr_wdata, ebr_we, ebr_re,
    output frame_len0, frame_len1, frame_done, frame_bank, overflow
  );
endinterface

// File: rtl/ebr_write_sequencer.sv
// Turns I2C byte strobes into addressed writes on one of two single-port EBR banks,
// tracks per-bank fill length, and slots reads into cycles without a write.
module ebr_write_sequencer #(
  parameter int ADDR_WIDTH = 9
) (
  input logic                  clock,
  input logic                  reset,
  ebr_write_sequencer_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITING, COMMIT} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_WIDTH:0] r_pointer;
  logic [ADDR_WIDTH:0] r_frameLen0;
  logic [ADDR_WIDTH:0] r_frameLen1;
  logic                r_curBank;
  logic                r_wrActivePrev;
  logic                r_overflow;
  logic                r_frameBank;
  logic                r_rdValid;
  logic                r_rdBank;
  logic                w_start;
  logic                w_strobeWriting;
  logic                w_write;
  logic                w_dropped;
  logic                w_grant;
  logic                w_commit;

  // Transaction sequencing: start on the wr_active rising edge, commit after it falls.
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.wr_active && !r_wrActivePrev) begin
          w_start     = 1'b1;
          w_nextState = WRITING;
        end
      end
      WRITING: if (!bus.wr_active) w_nextState = COMMIT;
      COMMIT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Writes cannot stall, so a read only gets the bank in a cycle without a real write.
  always_comb begin
    w_strobeWriting = (r_state == WRITING) && bus.wr_strobe && !reset;
    w_write         = w_strobeWriting && (r_pointer != FULL);
    w_dropped       = w_strobeWriting && (r_pointer == FULL);
    w_grant         = bus.rd_req && !w_write && !reset;
    w_commit        = (r_state == COMMIT) && !reset;

    bus.ebr_addr  = '0;
    bus.ebr_wdata = '0;
    bus.ebr_we    = 2'b00;
    bus.ebr_re    = 2'b00;
    if (w_write) begin
      bus.ebr_addr  = r_pointer[ADDR_WIDTH-1:0];
      bus.ebr_wdata = bus.wr_data;
      bus.ebr_we    = r_curBank ? 2'b10 : 2'b01;
    end else if (w_grant) begin
      bus.ebr_addr = bus.rd_addr;
      bus.ebr_re   = bus.rd_bank ? 2'b10 : 2'b01;
    end

    bus.rd_gnt     = w_grant;
    bus.rd_valid   = r_rdValid;
    bus.rd_data    = r_rdValid ? (r_rdBank ? bus.ebr_rdata1 : bus.ebr_rdata0) : 8'h00;
    bus.frame_len0 = r_frameLen0;
    bus.frame_len1 = r_frameLen1;
    bus.frame_done = w_commit;
    bus.frame_bank = w_commit ? r_curBank : r_frameBank;
    bus.overflow   = r_overflow;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_pointer      <= '0;
      r_frameLen0    <= '0;
      r_frameLen1    <= '0;
      r_curBank      <= 1'b0;
      r_wrActivePrev <= 1'b0;
      r_overflow     <= 1'b0;
      r_frameBank    <= 1'b0;
      r_rdValid      <= 1'b0;
      r_rdBank       <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_wrActivePrev <= bus.wr_active;
      r_rdValid      <= w_grant;
      if (w_grant) r_rdBank <= bus.rd_bank;
      if (w_start) begin
        r_pointer  <= '0;
        r_overflow <= 1'b0;
        r_curBank  <= bus.wr_select;
      end
      if (w_write) r_pointer <= r_pointer + 1'b1;
      if (w_dropped) r_overflow <= 1'b1;
      if (w_commit) begin
        r_frameBank <= r_curBank;
        if (r_curBank) r_frameLen1 <= r_pointer;
        else           r_frameLen0 <= r_pointer;
      end
    end
  end
endmodule
